// File: rtl/register_file_init.sv
// Register bank with two async read ports, one sync write port, optional zero register
// and a post-reset init sequencer. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module register_file_init #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 5,
   parameter int INIT_MODE = 1,
   parameter int ZERO_EN   = 1,
   parameter int ZERO_IDX  = 31
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] A,
   input  logic [ADDR_W-1:0] B,
   input  logic [ADDR_W-1:0] C,
   input  logic [DATA_W-1:0] Cdata,
   input  logic              W,
   output logic [DATA_W-1:0] Adata,
   output logic [DATA_W-1:0] Bdata,
   output logic              READY
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
      return (ZERO_EN != 0) && (addr == ADDR_W'(ZERO_IDX));
   endfunction

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] data;
      data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (state_q == S_RUN) && (wr_addr == addr)) data = wr_data;
`endif
      if (state_q != S_RUN || is_zero_reg(addr)) data = '0;
      return data;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt wraps to 0 on the final init write and is idle in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + ADDR_W'(1);
         if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = S_RUN;
      end
   end

   // Reset always wins over both init and user writes
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = C;
      wr_data = Cdata;
      if (!RST) begin
         if (state_q == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;
         end else begin
            wr_en = W && !is_zero_reg(C);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   always_comb begin
      READY = (state_q == S_RUN);
      Adata = read_port(A);
      Bdata = read_port(B);
   end

endmodule

// File: tb/tb_register_file_init.sv
// Directed bench for register_file_init: default instance plus an INIT_MODE=0, ZERO_EN=0 instance.
module tb_register_file_init;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  a, b, c;
   logic [63:0] cdata;
   logic        w;
   logic [63:0] adata, bdata;
   logic        ready;

   logic [4:0]  a2, b2, c2;
   logic [63:0] cdata2;
   logic        w2;
   logic [63:0] adata2, bdata2;
   logic        ready2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   register_file_init dut (
      .CLK(clk), .RST(rst), .A(a), .B(b), .C(c), .Cdata(cdata), .W(w),
      .Adata(adata), .Bdata(bdata), .READY(ready)
   );

   register_file_init #(.INIT_MODE(0), .ZERO_EN(0)) dut_z (
      .CLK(clk), .RST(rst), .A(a2), .B(b2), .C(c2), .Cdata(cdata2), .W(w2),
      .Adata(adata2), .Bdata(bdata2), .READY(ready2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] exp_pre;
      rst = 1'b1; w = 1'b0; a = '0; b = '0; c = '0; cdata = '0;
      w2 = 1'b0; a2 = '0; b2 = '0; c2 = '0; cdata2 = '0;

      tick();
      a = 5'd7; b = 5'd20; #1;
      chk("reset_ready", {63'd0, ready}, 64'd0);
      chk("reset_adata", adata, 64'd0);
      chk("reset_bdata", bdata, 64'd0);

      // Init: 32 edges, dropped write on the 10th
      rst = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         if (i == 10) begin w = 1'b1; c = 5'd5; cdata = 64'h55; end
         tick();
         w = 1'b0;
         chk($sformatf("init_ready_e%0d", i), {63'd0, ready}, (i == 32) ? 64'd1 : 64'd0);
         if (i == 20) chk("init_adata_zero", adata, 64'd0);
      end

      a = 5'd7; b = 5'd20; #1;
      chk("run_a7", adata, 64'd7);
      chk("run_b20", bdata, 64'd20);
      a = 5'd5; #1;
      chk("init_write_dropped", adata, 64'd5);

      // RUN write to reg 3
      w = 1'b1; c = 5'd3; cdata = 64'hDEAD_BEEF_0000_0001; a = 5'd3; b = 5'd4; #1;
`ifdef REGFILE_BYPASS_EN
      exp_pre = 64'hDEAD_BEEF_0000_0001;
`else
      exp_pre = 64'd3;
`endif
      chk("wr3_pre_edge", adata, exp_pre);
      chk("wr3_other_port", bdata, 64'd4);
      tick();
      w = 1'b0; #1;
      chk("wr3_post_edge", adata, 64'hDEAD_BEEF_0000_0001);
      b = 5'd3; #1;
      chk("same_addr_b", bdata, 64'hDEAD_BEEF_0000_0001);

      // Zero register
      w = 1'b1; c = 5'd31; cdata = 64'hFFFF_FFFF_FFFF_FFFF; a = 5'd31; b = 5'd31; #1;
      chk("xzr_pre_a", adata, 64'd0);
      chk("xzr_pre_b", bdata, 64'd0);
      tick();
      w = 1'b0; #1;
      chk("xzr_post_a", adata, 64'd0);
      chk("xzr_post_b", bdata, 64'd0);

      // Reset in RUN with a simultaneous write
      rst = 1'b1; w = 1'b1; c = 5'd8; cdata = 64'h1234;
      tick();
      w = 1'b0; a = 5'd3; #1;
      chk("run_reset_ready", {63'd0, ready}, 64'd0);
      chk("run_reset_adata", adata, 64'd0);

      // Restart init, then reset again at cycle 16
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk($sformatf("pre_rst_ready_e%0d", i), {63'd0, ready}, 64'd0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ready", {63'd0, ready}, 64'd0);
      for (int i = 1; i <= 32; i++) begin
         tick();
         chk($sformatf("reinit_ready_e%0d", i), {63'd0, ready}, (i == 32) ? 64'd1 : 64'd0);
      end
      a = 5'd3; b = 5'd8; #1;
      chk("reinit_a3", adata, 64'd3);
      chk("reinit_b8", bdata, 64'd8);

      // INIT_MODE=0, ZERO_EN=0 instance
      chk("z_ready", {63'd0, ready2}, 64'd1);
      for (int i = 0; i < 32; i++) begin
         a2 = i[4:0]; #1;
         chk($sformatf("z_read_%0d", i), adata2, 64'd0);
      end
      w2 = 1'b1; c2 = 5'd31; cdata2 = 64'h9; a2 = 5'd31; b2 = 5'd31;
      tick();
      w2 = 1'b0; #1;
      chk("z_r31_a", adata2, 64'h9);
      chk("z_r31_b", bdata2, 64'h9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
